mem_lsu_ctrl: RTL and testbench
===============================

// Module: mem_lsu_ctrl
// PURPOSE
//  MEM-stage load/store unit: turns the EX/MEM memory op into a valid/grant/response data-bus
//  transaction and returns the lane-aligned, sign/zero-extended load value as ld_dataM for
//  the MEM/WB register. Stalls the pipeline while a transaction is outstanding.
//  Flags misaligned accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT_CYC  255  max cycles in REQ+WAIT_RSP before bus error (>=2)
// PORTS
//  i_clk          in   1   clock, rising edge
//  i_rst          in   1   reset, asynchronous, active-high
//  i_mem_rdenM    in   1   load in MEM stage
//  i_mem_wrenM    in   1   store in MEM stage (never asserted together with i_mem_rdenM)
//  i_funct3M      in   3   LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010
//  i_alu_dataM    in   32  effective byte address
//  i_st_dataM     in   32  store source (rs2)
//  o_bus_req      out  1   request valid, held until i_bus_gnt
//  o_bus_we       out  1   1=write
//  o_bus_addr     out  32  word address ({addr[31:2],2'b00})
//  o_bus_wdata    out  32  lane-replicated store data
//  o_bus_strb     out  4   byte enables (0000 on reads)
//  i_bus_gnt      in   1   request accepted this cycle
//  i_bus_rvalid   in   1   read data / write ack valid
//  i_bus_rdata    in   32  read data
//  o_ld_dataM     out  32  extended load result (valid in DONE)
//  o_stall        out  1   freeze IF..MEM and hold MEM/WB input
//  o_misalign     out  1   1-cycle misaligned-access pulse
//  o_bus_err      out  1   1-cycle timeout pulse
// BEHAVIOUR
//  - Reset: state IDLE, timeout counter 0; all registered outputs 0; o_stall=0 while i_rst.
//  - FSM IDLE->REQ->WAIT_RSP->DONE->IDLE.
//  - IDLE: op = rden|wren. Misaligned (LH/LHU/SH addr[0]; LW/SW addr[1:0]!=0): o_misalign=1
//    that cycle, no bus activity, no stall, stay IDLE. Aligned op: latch addr/funct3/we,
//    form wdata/strb, go REQ; o_stall=1 combinationally in this same cycle.
//  - REQ: o_bus_req=1 with stable addr/we/wdata/strb; on i_bus_gnt -> WAIT_RSP.
//  - WAIT_RSP: i_bus_rvalid counted only here (>=1 cycle after gnt); loads capture extended
//    rdata into o_ld_dataM; -> DONE. Stores ignore rdata, o_ld_dataM=0.
//  - DONE: o_stall=0 so the pipe (and MEM/WB) advances; inputs ignored (same insn still
//    presented); -> IDLE. o_stall = IDLE&aligned op | REQ | WAIT_RSP.
//  - Timeout: counter clears on entering REQ, increments in REQ/WAIT_RSP; at TIMEOUT_CYC-1
//    without completion: o_bus_err pulse, o_bus_req dropped, o_ld_dataM=0, -> DONE.
//  - Store lanes: SB strb=0001<<a[1:0], wdata={4{d[7:0]}}; SH strb=a[1]?1100:0011,
//    wdata={2{d[15:0]}}; SW strb=1111, wdata=d.
//  - Load extract: byte=rdata[8*a[1:0]+:8], half=rdata[16*a[1]+:16]; LB/LH sign-extend,
//    LBU/LHU zero-extend, LW pass. Unknown funct3 treated as LW/SW.
//  - Async reset mid-transaction: immediate IDLE, o_bus_req=0; bus side must drop pending
//    response. gnt/rvalid outside REQ/WAIT_RSP ignored.
// STRUCTURE
//  - lsu_pkg: lsu_state_e {IDLE,REQ,WAIT_RSP,DONE}; funct3 localparams F3_B/H/W/BU/HU.
//  - Sub-module lsu_lane_fmt (combinational): store strb/wdata formatting + load
//    extract/extend; FSM, counter and bus registers stay in mem_lsu_ctrl.
// TESTING
//  - LW @0x100, gnt cycle 1, rvalid 2 cycles later, rdata=0xDEADBEEF -> req 1 cycle,
//    stall for 4 cycles, o_ld_dataM=0xDEADBEEF in DONE, stall=0 in DONE.
//  - LB @0x103, rdata=0x80FF_0000 -> o_ld_dataM=0xFFFFFF80; LBU same -> 0x00000080;
//    LH @0x102 rdata=0x8001_0000 -> 0xFFFF8001.
//  - SB @0x202 d=0x12345678 -> addr=0x200, strb=0100, wdata=0x78787878, we=1;
//    SH @0x202 -> strb=1100, wdata=0x56785678.
//  - LW @0x101 / SH @0x203 -> o_misalign pulse, o_bus_req never 1, o_stall=0.
//  - TIMEOUT_CYC=8, gnt never asserted -> o_bus_err pulse at 8th cycle, o_ld_dataM=0,
//    IDLE after DONE; next LW completes normally.
//  - i_rst in WAIT_RSP -> o_bus_req/o_stall 0 same cycle; late rvalid after release ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Any funct3 that is not a byte/half encoding for this direction acts as a word.
    function automatic lsu_size_e lsu_size(input logic [2:0] f3, input logic is_store);
        lsu_size_e sz;
        sz = SZ_W;
        if (f3 == F3_B || (!is_store && f3 == F3_BU)) begin
            sz = SZ_B;
        end else if (f3 == F3_H || (!is_store && f3 == F3_HU)) begin
            sz = SZ_H;
        end
        return sz;
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo,
                                            input logic is_store);
        logic mis;
        case (lsu_size(f3, is_store))
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte-lane formatting: store strobe/data replication and load extract/extend.
module lsu_lane_fmt
    import lsu_pkg::*;
(
    input  logic [2:0]  i_st_funct3,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_st_strb,
    output logic [31:0] o_st_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_st_strb  = 4'b1111;
        o_st_wdata = i_st_data;
        case (lsu_size(i_st_funct3, 1'b1))
            SZ_B: begin
                o_st_strb  = 4'b0001 << i_st_addr_lo;
                o_st_wdata = {4{i_st_data[7:0]}};
            end
            SZ_H: begin
                o_st_strb  = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_st_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                o_st_strb  = 4'b1111;
                o_st_wdata = i_st_data;
            end
        endcase
    end

    assign w_byte = i_ld_rdata[{i_ld_addr_lo, 3'b000} +: 8];
    assign w_half = i_ld_rdata[{i_ld_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_ld_data = i_ld_rdata;
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_ld_data = {24'h0, w_byte};
            F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_ld_data = {16'h0, w_half};
            default: o_ld_data = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu_ctrl.sv
// MEM-stage load/store unit: one bus transaction per memory op, stalling the pipe until done.
module mem_lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_rdenM,
    input  logic        i_mem_wrenM,
    input  logic [2:0]  i_funct3M,
    input  logic [31:0] i_alu_dataM,
    input  logic [31:0] i_st_dataM,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_strb,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_ld_dataM,
    output logic        o_stall,
    output logic        o_misalign,
    output logic        o_bus_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e         r_state;
    lsu_state_e         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_addr;
    logic [2:0]         r_funct3;
    logic               r_we;
    logic [31:0]        r_wdata;
    logic [3:0]         r_strb;
    logic [31:0]        r_ld_data;

    logic               w_op;
    logic               w_idle;
    logic               w_busy;
    logic               w_misalign;
    logic               w_start;
    logic               w_rsp;
    logic               w_tmo;
    logic [3:0]         w_st_strb;
    logic [31:0]        w_st_wdata;
    logic [31:0]        w_ld_ext;

    lsu_lane_fmt u_lane_fmt (
        .i_st_funct3  (i_funct3M),
        .i_st_addr_lo (i_alu_dataM[1:0]),
        .i_st_data    (i_st_dataM),
        .o_st_strb    (w_st_strb),
        .o_st_wdata   (w_st_wdata),
        .i_ld_funct3  (r_funct3),
        .i_ld_addr_lo (r_addr[1:0]),
        .i_ld_rdata   (i_bus_rdata),
        .o_ld_data    (w_ld_ext)
    );

    assign w_op       = i_mem_rdenM | i_mem_wrenM;
    assign w_idle     = (r_state == IDLE);
    assign w_busy     = (r_state == REQ) || (r_state == WAIT_RSP);
    assign w_misalign = w_idle & w_op & lsu_misaligned(i_funct3M, i_alu_dataM[1:0], i_mem_wrenM);
    assign w_start    = w_idle & w_op & ~w_misalign;
    assign w_rsp      = (r_state == WAIT_RSP) & i_bus_rvalid;
    // A response arriving in the final budget cycle still counts as completion.
    assign w_tmo      = w_busy & (r_cnt == CNT_MAX) & ~w_rsp;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_start) w_state_nxt = REQ;
            REQ: begin
                if (w_tmo) w_state_nxt = DONE;
                else if (i_bus_gnt) w_state_nxt = WAIT_RSP;
            end
            WAIT_RSP: if (w_rsp || w_tmo) w_state_nxt = DONE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_funct3  <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_ld_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_cnt    <= '0;
                r_addr   <= i_alu_dataM;
                r_funct3 <= i_funct3M;
                r_we     <= i_mem_wrenM;
                r_wdata  <= w_st_wdata;
                r_strb   <= i_mem_wrenM ? w_st_strb : 4'b0000;
            end else if (w_busy) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_rsp) begin
                r_ld_data <= r_we ? 32'h0 : w_ld_ext;
            end else if (w_tmo) begin
                r_ld_data <= 32'h0;
            end
        end
    end

    assign o_bus_req   = (r_state == REQ) & ~w_tmo;
    assign o_bus_we    = r_we;
    assign o_bus_addr  = {r_addr[31:2], 2'b00};
    assign o_bus_wdata = r_wdata;
    assign o_bus_strb  = r_strb;
    assign o_ld_dataM  = r_ld_data;
    assign o_stall     = ~i_rst & (w_start | w_busy);
    assign o_misalign  = w_misalign;
    assign o_bus_err   = w_tmo;

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Directed bench for mem_lsu_ctrl: loads, stores, misalignment, timeout and async reset.
module tb_mem_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rden, wren;
    logic [2:0]  funct3;
    logic [31:0] alu_data, st_data;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_strb;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;
    logic [31:0] ld_data;
    logic        stall, misalign, bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_lsu_ctrl #(.TIMEOUT_CYC(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mem_rdenM  (rden),
        .i_mem_wrenM  (wren),
        .i_funct3M    (funct3),
        .i_alu_dataM  (alu_data),
        .i_st_dataM   (st_data),
        .o_bus_req    (bus_req),
        .o_bus_we     (bus_we),
        .o_bus_addr   (bus_addr),
        .o_bus_wdata  (bus_wdata),
        .o_bus_strb   (bus_strb),
        .i_bus_gnt    (bus_gnt),
        .i_bus_rvalid (bus_rvalid),
        .i_bus_rdata  (bus_rdata),
        .o_ld_dataM   (ld_data),
        .o_stall      (stall),
        .o_misalign   (misalign),
        .o_bus_err    (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Entered just after a rising edge with the DUT idle; gnt in first REQ cycle,
    // rvalid two cycles after gnt.
    task automatic xfer(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input logic [31:0] exp_ld,
                        input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata);
        int n_stall = 0;
        int n_req = 0;
        rden = ~we; wren = we; funct3 = f3; alu_data = addr; st_data = sdata;
        @(negedge clk); n_stall += int'(stall); n_req += int'(bus_req);
        @(posedge clk); #1 bus_gnt = 1'b1;
        @(negedge clk); n_stall += int'(stall); n_req += int'(bus_req);
        check({tag, "_addr"}, bus_addr, exp_addr);
        check({tag, "_we"}, {31'h0, bus_we}, {31'h0, we});
        check({tag, "_strb"}, {28'h0, bus_strb}, {28'h0, exp_strb});
        if (we) check({tag, "_wdata"}, bus_wdata, exp_wdata);
        @(posedge clk); #1 bus_gnt = 1'b0;
        @(negedge clk); n_stall += int'(stall); n_req += int'(bus_req);
        @(posedge clk); #1 bus_rvalid = 1'b1; bus_rdata = rdata;
        @(negedge clk); n_stall += int'(stall); n_req += int'(bus_req);
        @(posedge clk); #1 bus_rvalid = 1'b0; bus_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        check({tag, "_done_stall"}, {31'h0, stall}, 32'h0);
        check({tag, "_ld"}, ld_data, exp_ld);
        check({tag, "_stall_cycles"}, n_stall, 32'd4);
        check({tag, "_req_cycles"}, n_req, 32'd1);
        @(posedge clk); #1 rden = 1'b0; wren = 1'b0;
        @(negedge clk);
        check({tag, "_idle_stall"}, {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic misaligned_op(input string tag, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr);
        rden = ~we; wren = we; funct3 = f3; alu_data = addr; st_data = 32'hFFFF_FFFF;
        @(negedge clk);
        check({tag, "_pulse"}, {31'h0, misalign}, 32'h1);
        check({tag, "_stall"}, {31'h0, stall}, 32'h0);
        check({tag, "_req"}, {31'h0, bus_req}, 32'h0);
        @(posedge clk); #1 rden = 1'b0; wren = 1'b0;
        @(negedge clk);
        check({tag, "_pulse_end"}, {31'h0, misalign}, 32'h0);
        check({tag, "_req_after"}, {31'h0, bus_req}, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        int err_early;
        int req_cnt;
        rst = 1'b1; rden = 1'b1; wren = 1'b0; funct3 = 3'b010;
        alu_data = 32'h100; st_data = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        @(posedge clk); @(negedge clk);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_req", {31'h0, bus_req}, 32'h0);
        check("rst_ld", ld_data, 32'h0);
        check("rst_strb", {28'h0, bus_strb}, 32'h0);
        @(posedge clk); #1 rst = 1'b0; rden = 1'b0;
        @(posedge clk); #1;

        xfer("lw",  1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h100, 4'h0, 32'h0);
        xfer("lb",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 32'hFFFFFF80, 32'h100, 4'h0, 32'h0);
        xfer("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 32'h00000080, 32'h100, 4'h0, 32'h0);
        xfer("lh",  1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 32'hFFFF8001, 32'h100, 4'h0, 32'h0);
        xfer("lhu", 1'b0, 3'b101, 32'h100, 32'h0, 32'h1234F00D, 32'h0000F00D, 32'h100, 4'h0, 32'h0);
        xfer("sb",  1'b1, 3'b000, 32'h202, 32'h12345678, 32'hFFFFFFFF, 32'h0, 32'h200, 4'b0100,
             32'h78787878);
        xfer("sh",  1'b1, 3'b001, 32'h202, 32'h12345678, 32'hFFFFFFFF, 32'h0, 32'h200, 4'b1100,
             32'h56785678);
        xfer("sw",  1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h0, 32'h204, 4'b1111,
             32'hCAFEF00D);

        misaligned_op("mis_lw", 1'b0, 3'b010, 32'h101);
        misaligned_op("mis_sh", 1'b1, 3'b001, 32'h203);

        xfer("lw2", 1'b0, 3'b010, 32'h104, 32'h0, 32'h11223344, 32'h11223344, 32'h104, 4'h0, 32'h0);

        // Timeout: gnt never arrives; err expected in the 8th REQ cycle.
        err_early = 0; req_cnt = 0;
        rden = 1'b1; funct3 = 3'b010; alu_data = 32'h300;
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i < 8) begin
                err_early += int'(bus_err);
                req_cnt   += int'(bus_req);
            end else begin
                check("tmo_err_pulse", {31'h0, bus_err}, 32'h1);
                check("tmo_req_dropped", {31'h0, bus_req}, 32'h0);
            end
            @(posedge clk); #1;
        end
        check("tmo_no_early_err", err_early, 32'd0);
        check("tmo_req_held", req_cnt, 32'd7);
        @(negedge clk);
        check("tmo_done_ld", ld_data, 32'h0);
        check("tmo_done_stall", {31'h0, stall}, 32'h0);
        check("tmo_err_single", {31'h0, bus_err}, 32'h0);
        @(posedge clk); #1 rden = 1'b0;
        @(negedge clk);
        check("tmo_idle_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        xfer("lw_after_tmo", 1'b0, 3'b010, 32'h108, 32'h0, 32'hA5A5C3C3, 32'hA5A5C3C3, 32'h108,
             4'h0, 32'h0);

        // Async reset while waiting for the response.
        rden = 1'b1; funct3 = 3'b010; alu_data = 32'h400;
        @(posedge clk); #1 bus_gnt = 1'b1;
        @(posedge clk); #1 bus_gnt = 1'b0;
        @(negedge clk);
        check("rstw_stall_before", {31'h0, stall}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check("rstw_req", {31'h0, bus_req}, 32'h0);
        check("rstw_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1 rst = 1'b0; rden = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hBADBAD00;
        @(negedge clk);
        check("rstw_late_stall", {31'h0, stall}, 32'h0);
        check("rstw_late_req", {31'h0, bus_req}, 32'h0);
        @(posedge clk); #1 bus_rvalid = 1'b0;
        @(negedge clk);
        check("rstw_late_ld", ld_data, 32'h0);
        @(posedge clk); #1;
        xfer("lw_after_rst", 1'b0, 3'b010, 32'h40C, 32'h0, 32'h0BADF00D, 32'h0BADF00D, 32'h40C,
             4'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
